// File: rtl/autobus_pkg.sv
// autobus_pkg: shared default widths, error codes, FSM encoding and the
// error-priority picker used by the autobus receive path.
package autobus_pkg;

    localparam int DWID_DEF = 16;
    localparam int CWID_DEF = 16;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_NOSOP  = 3'd1;
    localparam logic [2:0] ERR_DUPSOP = 3'd2;
    localparam logic [2:0] ERR_DATA   = 3'd3;
    localparam logic [2:0] ERR_LEN    = 3'd4;
    localparam logic [2:0] ERR_FRM    = 3'd5;
    localparam logic [2:0] ERR_GAP    = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } rx_state_e;

    // One flag per error class that can fire on a single beat.
    typedef struct packed {
        logic nosop;
        logic dupsop;
        logic data;
        logic len;
        logic frm;
        logic gap;
    } err_vec_t;

    // Several errors on one beat collapse to the highest-priority code.
    function automatic logic [2:0] err_pick(input err_vec_t e);
        if (e.nosop)       return ERR_NOSOP;
        else if (e.dupsop) return ERR_DUPSOP;
        else if (e.data)   return ERR_DATA;
        else if (e.len)    return ERR_LEN;
        else if (e.frm)    return ERR_FRM;
        else if (e.gap)    return ERR_GAP;
        else               return ERR_NONE;
    endfunction

endpackage

// File: rtl/autobus_sat_cnt.sv
// autobus_sat_cnt: W-bit up counter that sticks at all-ones.
// clr restarts the count; clr together with inc restarts it at 1, which lets
// the beat counter count the first beat of a packet in the same cycle.
module autobus_sat_cnt
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count register: restart on clr, otherwise increment until all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q    <= '0;
            r_q[0] <= inc;
        end else if (inc && !(&r_q)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/autobus_rx.sv
// autobus_rx: receive end of the autobus stream. Drives rdy, checks packet
// and frame framing plus the per-packet data ramp, reports each error as a
// one-cycle err_vld pulse and keeps saturating good-packet, good-frame and
// error counters.
// Optional feature: define AUTOBUS_RX_GAP_CHK_EN to add the pkt_interval
// input and the minimum eop-to-sop gap check (code 6).
module autobus_rx
    import autobus_pkg::*;
#(
    parameter int DWID = DWID_DEF,
    parameter int CWID = CWID_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_en,
    input  logic [15:0]     sop_len,
    input  logic [15:0]     sof_len,
    input  logic            sop,
    input  logic            eop,
    input  logic            sof,
    input  logic            eof,
    input  logic [DWID-1:0] dat,
    input  logic            dav,
`ifdef AUTOBUS_RX_GAP_CHK_EN
    input  logic [15:0]     pkt_interval,
`endif
    output logic            rdy,
    output logic [31:0]     pkt_cnt,
    output logic [CWID-1:0] frm_cnt,
    output logic [CWID-1:0] err_cnt,
    output logic            err_vld,
    output logic [2:0]      err_code,
    output logic            err_flag
);

    rx_state_e       r_state, w_state_nxt;

    // Packet tracking
    logic [DWID-1:0] r_exp, w_exp_cur;
    logic [15:0]     r_sop_len, w_len_cur;
    logic [CWID-1:0] w_beat_q, w_beat_n;
    logic            r_data_seen, r_pkt_bad;

    // Frame tracking
    logic            r_frm_open, r_frm_bad;
    logic [15:0]     r_sof_len, w_sof_len_cur;
    logic [CWID-1:0] r_frm_pkts, w_pkts_cur;

    // Per-beat decode
    logic            w_sop_beat, w_beat_ok, w_close, w_data_bad;
    logic            w_opening, w_frm_open_now, w_last_pkt, w_frm_close;
    logic            w_beat_pkt_err, w_any_err, w_pkt_good, w_frm_good;
    logic            w_gap_err;
    err_vec_t        w_err;
    logic [2:0]      w_code;

    // Output registers
    logic            r_rdy, r_err_vld, r_err_flag;
    logic [2:0]      r_err_code;

    // Beat decode, error detection and next-state selection.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        w_state_nxt = r_state;

        // A sop beat starts a packet from any state; a beat in IDLE without sop is dropped.
        w_sop_beat  = dav & sop;
        w_beat_ok   = dav & (sop | (r_state == ST_PKT));
        w_close     = w_beat_ok & eop;

        w_exp_cur   = w_sop_beat ? '0 : r_exp;
        w_len_cur   = w_sop_beat ? sop_len : r_sop_len;
        w_beat_n    = w_sop_beat ? CWID'(1)
                    : ((&w_beat_q) ? w_beat_q : w_beat_q + CWID'(1));
        w_data_bad  = w_beat_ok & (dat != w_exp_cur);

        // The frame may open on this very beat, so use its fresh length and a zero packet count.
        w_opening      = w_beat_ok & sof & sop & !r_frm_open;
        w_frm_open_now = r_frm_open | w_opening;
        w_sof_len_cur  = w_opening ? sof_len : r_sof_len;
        w_pkts_cur     = w_opening ? '0 : r_frm_pkts;
        w_last_pkt     = w_close & w_frm_open_now
                       & ((32'(w_pkts_cur) + 32'd1) == 32'(w_sof_len_cur));
        // Any eof on an accepted beat closes the open frame, legal or not, so the next sof is clean.
        w_frm_close    = w_frm_open_now & (w_last_pkt | (w_beat_ok & eof));

        w_err        = '0;
        w_err.nosop  = dav & !sop & (r_state == ST_IDLE);
        w_err.dupsop = dav & sop & (r_state == ST_PKT);
        w_err.data   = w_data_bad & (w_sop_beat | !r_data_seen);
        w_err.len    = w_close & (32'(w_beat_n) != 32'(w_len_cur));
        w_err.frm    = w_beat_ok & ((sof & !(sop & !r_frm_open))
                                  | (eof & !w_last_pkt)
                                  | (w_last_pkt & !eof));
        w_err.gap    = w_gap_err;
        w_any_err    = |w_err;
        w_code       = err_pick(w_err);

        // DUPSOP belongs to the aborted packet; the restarted packet starts clean.
        w_beat_pkt_err = w_data_bad | w_err.len | w_err.frm | w_err.gap;
        w_pkt_good     = w_close & !w_beat_pkt_err & (w_sop_beat | !r_pkt_bad);
        w_frm_good     = w_last_pkt & eof & !w_any_err & (w_opening | !r_frm_bad);

        if (w_beat_ok) begin
            w_state_nxt = eop ? ST_IDLE : ST_PKT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Per-packet tracking: expected ramp value, latched length, error history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp       <= '0;
            r_sop_len   <= '0;
            r_data_seen <= 1'b0;
            r_pkt_bad   <= 1'b0;
        end else if (w_beat_ok) begin
            r_exp <= (&w_exp_cur) ? w_exp_cur : w_exp_cur + DWID'(1);
            if (w_sop_beat) begin
                r_sop_len   <= sop_len;
                r_data_seen <= w_data_bad;
                r_pkt_bad   <= w_beat_pkt_err;
            end else begin
                r_data_seen <= r_data_seen | w_data_bad;
                r_pkt_bad   <= r_pkt_bad | w_beat_pkt_err;
            end
        end
    end

    // Frame tracking: open flag, latched packets-per-frame, packets closed so far, error history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_open <= 1'b0;
            r_frm_bad  <= 1'b0;
            r_sof_len  <= '0;
            r_frm_pkts <= '0;
        end else begin
            if (w_frm_close) begin
                r_frm_open <= 1'b0;
                r_frm_pkts <= '0;
            end else if (w_opening) begin
                r_frm_open <= 1'b1;
                r_frm_pkts <= w_close ? CWID'(1) : '0;
            end else if (w_close && r_frm_open && !(&r_frm_pkts)) begin
                r_frm_pkts <= r_frm_pkts + CWID'(1);
            end

            if (w_opening) begin
                r_sof_len <= sof_len;
                r_frm_bad <= w_any_err;
            end else if (r_frm_open) begin
                r_frm_bad <= r_frm_bad | w_any_err;
            end
        end
    end

`ifdef AUTOBUS_RX_GAP_CHK_EN
    logic [15:0] r_gap_cnt, r_gap_min;
    logic        r_gap_armed;

    // Idle-cycle counter from the last eop; the minimum gap is latched with that eop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt   <= '0;
            r_gap_min   <= '0;
            r_gap_armed <= 1'b0;
        end else if (w_close) begin
            r_gap_cnt   <= '0;
            r_gap_min   <= pkt_interval;
            r_gap_armed <= 1'b1;
        end else if (!(&r_gap_cnt)) begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
        end
    end

    // Only a sop that opens a packet from IDLE is gap-checked; none before the first eop.
    assign w_gap_err = dav & sop & (r_state == ST_IDLE) & r_gap_armed
                     & (r_gap_cnt < r_gap_min);
`else
    assign w_gap_err = 1'b0;
`endif

    // Ready and error reporting registers; err_code holds until the next error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy      <= 1'b0;
            r_err_vld  <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_flag <= 1'b0;
        end else begin
            r_rdy      <= rx_en;
            r_err_vld  <= w_any_err;
            r_err_flag <= r_err_flag | w_any_err;
            if (w_any_err) begin
                r_err_code <= w_code;
            end
        end
    end

    autobus_sat_cnt #(.W(CWID)) u_beat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_sop_beat),
        .inc (w_beat_ok),
        .q   (w_beat_q)
    );

    autobus_sat_cnt #(.W(32)) u_pkt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (w_pkt_good),
        .q   (pkt_cnt)
    );

    autobus_sat_cnt #(.W(CWID)) u_frm_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (w_frm_good),
        .q   (frm_cnt)
    );

    autobus_sat_cnt #(.W(CWID)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (w_any_err),
        .q   (err_cnt)
    );

    assign rdy      = r_rdy;
    assign err_vld  = r_err_vld;
    assign err_code = r_err_code;
    assign err_flag = r_err_flag;

endmodule

// File: tb/tb_autobus_rx.sv
// tb_autobus_rx: directed scoreboard bench for autobus_rx. Each driven beat
// that must raise an error pushes {cycle, code} to a queue; a monitor pops
// and compares when the DUT reports. Counters are checked after each phase
// against bench-kept expected totals. A second DWID=8 instance covers the
// saturating ramp.
module tb_autobus_rx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rx_en;
    logic [15:0] sop_len, sof_len;
    logic        sop, eop, sof, eof, dav;
    logic [15:0] dat;
`ifdef AUTOBUS_RX_GAP_CHK_EN
    logic [15:0] pkt_interval;
`endif
    logic        rdy, err_vld, err_flag;
    logic [31:0] pkt_cnt;
    logic [15:0] frm_cnt, err_cnt;
    logic [2:0]  err_code;

    // Signals of the DWID=8 ramp-saturation instance
    logic [15:0] s_sop_len;
    logic [15:0] s_sof_len = 16'd0;
    logic        s_sop, s_eop, s_dav;
    logic        s_sof = 1'b0;
    logic        s_eof = 1'b0;
    logic [7:0]  s_dat;
    logic        s_rdy, s_err_vld, s_err_flag;
    logic [31:0] s_pkt_cnt;
    logic [15:0] s_frm_cnt, s_err_cnt;
    logic [2:0]  s_err_code;

    autobus_rx #(.DWID(16), .CWID(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .rx_en        (rx_en),
        .sop_len      (sop_len),
        .sof_len      (sof_len),
        .sop          (sop),
        .eop          (eop),
        .sof          (sof),
        .eof          (eof),
        .dat          (dat),
        .dav          (dav),
`ifdef AUTOBUS_RX_GAP_CHK_EN
        .pkt_interval (pkt_interval),
`endif
        .rdy          (rdy),
        .pkt_cnt      (pkt_cnt),
        .frm_cnt      (frm_cnt),
        .err_cnt      (err_cnt),
        .err_vld      (err_vld),
        .err_code     (err_code),
        .err_flag     (err_flag)
    );

    autobus_rx #(.DWID(8), .CWID(16)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .rx_en        (rx_en),
        .sop_len      (s_sop_len),
        .sof_len      (s_sof_len),
        .sop          (s_sop),
        .eop          (s_eop),
        .sof          (s_sof),
        .eof          (s_eof),
        .dat          (s_dat),
        .dav          (s_dav),
`ifdef AUTOBUS_RX_GAP_CHK_EN
        .pkt_interval (pkt_interval),
`endif
        .rdy          (s_rdy),
        .pkt_cnt      (s_pkt_cnt),
        .frm_cnt      (s_frm_cnt),
        .err_cnt      (s_err_cnt),
        .err_vld      (s_err_vld),
        .err_code     (s_err_code),
        .err_flag     (s_err_flag)
    );

    typedef struct {
        int cyc;
        int code;
    } exp_err_t;

    exp_err_t sb_q[$];
    int       cyc = 0;
    int       n_chk = 0;
    int       n_fail = 0;
    int       exp_pkt = 0;
    int       exp_frm = 0;
    int       exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Error monitor: every err_vld must match the oldest expected event on its cycle.
    always @(negedge clk) begin : monitor
        exp_err_t e;
        if (!rst) begin
            if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                check("err_vld", 32'(err_vld), 32'd1);
                check("err_code", 32'(err_code), 32'(e.code));
            end else if (err_vld) begin
                check("err_spurious_code", 32'(err_code), 32'd0);
            end
        end
    end

    // One beat, sampled at the next rising edge; a nonzero code is expected one cycle later.
    task automatic beat(input bit b_sop, input bit b_eop, input bit b_sof, input bit b_eof,
                        input logic [15:0] d, input int code);
        @(negedge clk);
        dav = 1'b1;
        sop = b_sop;
        eop = b_eop;
        sof = b_sof;
        eof = b_eof;
        dat = d;
        if (code != 0) sb_q.push_back('{cyc + 1, code});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dav = 1'b0;
            sop = 1'b0;
            eop = 1'b0;
            sof = 1'b0;
            eof = 1'b0;
        end
    endtask

    // Ramp packet of n beats; bad_idx beat carries 99; codes expected on first and eop beat.
    task automatic send_pkt(input int n, input bit with_eop, input bit f_sof, input bit f_eof,
                            input int bad_idx, input int sop_code, input int eop_code);
        for (int i = 0; i < n; i++) begin
            logic [15:0] d;
            int          code;
            bit          last;
            last = with_eop && (i == n - 1);
            d    = 16'(i);
            code = 0;
            if (i == 0) code = sop_code;
            if (i == bad_idx) begin
                d = 16'd99;
                if (code == 0) code = 3;
            end
            if (last && code == 0) code = eop_code;
            beat(i == 0, last, f_sof && (i == 0), f_eof && last, d, code);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt_cnt"}, pkt_cnt, 32'(exp_pkt));
        check({tag, "_frm_cnt"}, 32'(frm_cnt), 32'(exp_frm));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap_code;
`ifdef AUTOBUS_RX_GAP_CHK_EN
        gap_code     = 6;
        pkt_interval = 16'd8;
`else
        gap_code     = 0;
`endif
        rst = 1'b1; rx_en = 1'b0;
        sop_len = 16'd256; sof_len = 16'd4;
        dav = 1'b0; sop = 1'b0; eop = 1'b0; sof = 1'b0; eof = 1'b0; dat = '0;
        s_sop_len = 16'd300; s_dav = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_dat = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_err_vld", 32'(err_vld), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check_counts("rst");
        rst = 1'b0;
        rx_en = 1'b1;
        check("rdy_lag", 32'(rdy), 32'd0);
        @(negedge clk);
        check("rdy_follow", 32'(rdy), 32'd1);

        // 1: one frame of four clean 256-beat packets, gap 256
        for (int p = 0; p < 4; p++) begin
            send_pkt(256, 1'b1, p == 0, p == 3, -1, 0, 0);
            idle(256);
        end
        exp_pkt = 4; exp_frm = 1;
        check_counts("clean_frame");
        check("clean_err_flag", 32'(err_flag), 32'd0);

        // 2: data error on beat 10, reported once
        send_pkt(256, 1'b1, 1'b0, 1'b0, 10, 0, 0);
        idle(10);
        exp_err = 1;
        check_counts("data_err");
        check("data_err_flag", 32'(err_flag), 32'd1);

        // 3: short packet (LEN), then a beat without sop while idle (NOSOP)
        send_pkt(200, 1'b1, 1'b0, 1'b0, -1, 0, 4);
        idle(10);
        beat(1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 1);
        idle(10);
        exp_err = 3;
        check_counts("len_nosop");
        check("nosop_code_hold", 32'(err_code), 32'd1);

        // 4: sop repeated at beat 50; the restarted clean packet counts
        send_pkt(50, 1'b0, 1'b0, 1'b0, -1, 0, 0);
        send_pkt(256, 1'b1, 1'b0, 1'b0, -1, 2, 0);
        idle(10);
        exp_err = 4; exp_pkt = 5;
        check_counts("dupsop");

        // 5: sof_len=2 but eof on the first packet
        sof_len = 16'd2;
        send_pkt(256, 1'b1, 1'b1, 1'b1, -1, 0, 5);
        idle(10);
        exp_err = 5;
        check_counts("early_eof");

        // Reset in the middle of a packet
        send_pkt(100, 1'b0, 1'b0, 1'b0, -1, 0, 0);
        @(negedge clk);
        dav = 1'b0; sop = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        exp_pkt = 0; exp_frm = 0; exp_err = 0;
        check_counts("mid_rst");
        check("mid_rst_flag", 32'(err_flag), 32'd0);
        check("mid_rst_code", 32'(err_code), 32'd0);
        check("mid_rst_rdy", 32'(rdy), 32'd0);
        rst = 1'b0;
        idle(2);
        send_pkt(256, 1'b1, 1'b0, 1'b0, -1, 0, 0);
        idle(10);
        exp_pkt = 1;
        check_counts("post_rst");

        // Frame of one packet without eof is an error and closes the frame; the next frame is clean
        sof_len = 16'd1;
        send_pkt(256, 1'b1, 1'b1, 1'b0, -1, 0, 5);
        idle(10);
        send_pkt(256, 1'b1, 1'b1, 1'b1, -1, 0, 0);
        idle(10);
        exp_err = 1; exp_pkt = 2; exp_frm = 1;
        check_counts("missing_eof");

        // 6: gap of 3 then gap of 8 against a minimum of 8
        sop_len = 16'd4;
        send_pkt(4, 1'b1, 1'b0, 1'b0, -1, 0, 0);
        idle(3);
        send_pkt(4, 1'b1, 1'b0, 1'b0, -1, gap_code, 0);
        idle(8);
        send_pkt(4, 1'b1, 1'b0, 1'b0, -1, 0, 0);
        idle(10);
        if (gap_code != 0) begin
            exp_pkt = exp_pkt + 2; exp_err = exp_err + 1;
        end else begin
            exp_pkt = exp_pkt + 3;
        end
        check_counts("gap");

        // Sweep: DWID=8, 300-beat packet, ramp saturates at 255
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            s_dav = 1'b1;
            s_sop = (i == 0);
            s_eop = (i == 299);
            s_dat = (i > 255) ? 8'hFF : 8'(i);
        end
        @(negedge clk);
        s_dav = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_pkt_cnt", s_pkt_cnt, 32'd1);
        check("sat_err_cnt", 32'(s_err_cnt), 32'd0);
        check("sat_err_flag", 32'(s_err_flag), 32'd0);
        check("sat_err_vld", 32'(s_err_vld), 32'd0);
        check("sat_err_code", 32'(s_err_code), 32'd0);
        check("sat_frm_cnt", 32'(s_frm_cnt), 32'd0);
        check("sat_rdy", 32'(s_rdy), 32'd1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
